// File: rtl/rv32i_mc_control.sv
// Multicycle control FSM for the RV32I core: sequences fetch, decode, execute,
// memory access and writeback, with memory-timeout and illegal-opcode halts.
module rv32i_mc_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  sel_wb,
  output logic [1:0]  sel_pc,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] instr_retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR
  } cls_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  cls_t       cls, dec_cls;
  logic       dec_legal, dec_sys;
  logic [1:0] err_nxt;
  logic [7:0] wait_cnt;
  logic       retire;

  always_comb begin
    dec_cls   = C_ALU;
    dec_legal = 1'b1;
    dec_sys   = 1'b0;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: dec_cls = C_ALU;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b1110011: begin
        dec_legal = 1'b0;
        dec_sys   = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 2'b00;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    rf_we     = 1'b0;
    sel_wb    = 2'b00;
    sel_pc    = 2'b00;
    retire    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (wait_cnt == TMO) begin
          state_nxt = S_HALT;
          err_nxt   = 2'b10;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_HALT;
          err_nxt   = dec_sys ? 2'b11 : 2'b01;
        end
      end
      S_EXEC: begin
        case (cls)
          C_BRANCH: begin
            pc_we     = 1'b1;
            sel_pc    = branch_taken ? 2'b01 : 2'b00;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
          C_LOAD, C_STORE: state_nxt = S_MEM;
          default:         state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == C_STORE);
        if (dmem_ready) begin
          if (cls == C_STORE) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wait_cnt == TMO) begin
          state_nxt = S_HALT;
          err_nxt   = 2'b10;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
        case (cls)
          C_LOAD: sel_wb = 2'b01;
          C_JAL: begin
            sel_wb = 2'b10;
            sel_pc = 2'b01;
          end
          C_JALR: begin
            sel_wb = 2'b10;
            sel_pc = 2'b10;
          end
          default: ;
        endcase
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cls           <= C_ALU;
      err_code      <= 2'b00;
      wait_cnt      <= '0;
      instr_retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        cls <= dec_cls;
      if (state_nxt == S_HALT && state != S_HALT)
        err_code <= err_nxt;
      if (retire)
        instr_retired <= instr_retired + 32'd1;
      // Counter restarts only on entry; staying in FETCH/MEM keeps counting waits.
      if (state_nxt != state && (state_nxt == S_FETCH || state_nxt == S_MEM))
        wait_cnt <= '0;
      else if ((imem_req && !imem_ready) || (dmem_req && !dmem_ready))
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_rv32i_mc_control.sv
// Directed bench for rv32i_mc_control: instruction classes, memory waits,
// halts and the fetch timeout (MEM_TIMEOUT = 4).
module tb_rv32i_mc_control;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic [1:0]  sel_wb;
  logic [1:0]  sel_pc;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] instr_retired;

  int checks = 0;
  int errors = 0;

  rv32i_mc_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .sel_wb(sel_wb), .sel_pc(sel_pc), .halted(halted),
    .err_code(err_code), .instr_retired(instr_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, sel_wb, sel_pc}
  logic [9:0] ctl;
  assign ctl = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, sel_wb, sel_pc};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'b0110011; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;
    #2;
    chk("rst_ctl", 32'(ctl), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_err", 32'(err_code), 32'h0);
    chk("rst_ret", instr_retired, 32'h0);
    #10 rst_n = 1'b1;

    // ALU op: FETCH, DECODE, EXEC, WB
    step(); chk("alu_fetch", 32'(ctl), 32'(10'b1001000000));
    step(); chk("alu_decode", 32'(ctl), 32'h0);
    step(); chk("alu_exec", 32'(ctl), 32'h0);
    step(); chk("alu_wb", 32'(ctl), 32'(10'b0000110000));
    chk("alu_ret_pre", instr_retired, 32'd0);
    step(); chk("alu_ret", instr_retired, 32'd1);
    chk("alu_refetch", 32'(ctl), 32'(10'b1001000000));

    // Load with three data-memory wait cycles
    opcode = 7'b0000011; dmem_ready = 1'b0;
    step(); chk("ld_decode", 32'(ctl), 32'h0);
    step(); chk("ld_exec", 32'(ctl), 32'h0);
    step(); chk("ld_mem1", 32'(ctl), 32'(10'b0100000000));
    step(); chk("ld_mem2", 32'(ctl), 32'(10'b0100000000));
    step(); chk("ld_mem3", 32'(ctl), 32'(10'b0100000000));
    step(); dmem_ready = 1'b1; #1;
    chk("ld_mem4", 32'(ctl), 32'(10'b0100000000));
    step(); chk("ld_wb", 32'(ctl), 32'(10'b0000110100));
    chk("ld_ret_pre", instr_retired, 32'd1);
    step(); chk("ld_ret", instr_retired, 32'd2);

    // Branch taken, then not taken
    opcode = 7'b1100011; branch_taken = 1'b1;
    step(); chk("bt_decode", 32'(ctl), 32'h0);
    step(); chk("bt_exec", 32'(ctl), 32'(10'b0000100001));
    step(); chk("bt_ret", instr_retired, 32'd3);
    chk("bt_fetch", 32'(ctl), 32'(10'b1001000000));
    branch_taken = 1'b0;
    step(); step(); chk("bn_exec", 32'(ctl), 32'(10'b0000100000));
    step(); chk("bn_ret", instr_retired, 32'd4);

    // JAL, JALR
    opcode = 7'b1101111;
    step(); step(); chk("jal_exec", 32'(ctl), 32'h0);
    step(); chk("jal_wb", 32'(ctl), 32'(10'b0000111001));
    step(); chk("jal_ret", instr_retired, 32'd5);
    opcode = 7'b1100111;
    step(); step(); step(); chk("jalr_wb", 32'(ctl), 32'(10'b0000111010));
    step(); chk("jalr_ret", instr_retired, 32'd6);

    // Zero-wait store
    opcode = 7'b0100011;
    step(); step(); step(); chk("st_mem", 32'(ctl), 32'(10'b0110100000));
    step(); chk("st_ret", instr_retired, 32'd7);

    // Illegal opcode halts with err 01 and does not retire
    opcode = 7'b0000000;
    step(); chk("ill_decode_halted", 32'(halted), 32'h0);
    step(); chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_err", 32'(err_code), 32'h1);
    chk("ill_ctl", 32'(ctl), 32'h0);
    step(); step(); step();
    chk("ill_stay_ctl", 32'(ctl), 32'h0);
    chk("ill_stay_halted", 32'(halted), 32'h1);
    chk("ill_ret", instr_retired, 32'd7);

    // Reset pulse then ECALL/EBREAK halts with err 11
    rst_n = 1'b0; #1;
    chk("rst2_halted", 32'(halted), 32'h0);
    chk("rst2_err", 32'(err_code), 32'h0);
    chk("rst2_ret", instr_retired, 32'h0);
    rst_n = 1'b1; opcode = 7'b1110011;
    step(); chk("sys_fetch", 32'(ctl), 32'(10'b1001000000));
    step(); step();
    chk("sys_halted", 32'(halted), 32'h1);
    chk("sys_err", 32'(err_code), 32'h3);

    // Fetch timeout: imem_ready never arrives
    rst_n = 1'b0; imem_ready = 1'b0; opcode = 7'b0110011; #1;
    rst_n = 1'b1;
    step(); chk("to_f1", 32'(ctl), 32'(10'b1000000000));
    step(); step(); step();
    step(); chk("to_f5_ctl", 32'(ctl), 32'(10'b1000000000));
    chk("to_f5_halted", 32'(halted), 32'h0);
    step(); chk("to_halted", 32'(halted), 32'h1);
    chk("to_err", 32'(err_code), 32'h2);
    chk("to_ctl", 32'(ctl), 32'h0);

    // Ready in the fifth fetch cycle wins over the timeout
    rst_n = 1'b0; #1;
    rst_n = 1'b1;
    step(); step(); step(); step();
    step(); imem_ready = 1'b1; #1;
    chk("tw_f5_ctl", 32'(ctl), 32'(10'b1001000000));
    step(); chk("tw_decode_halted", 32'(halted), 32'h0);
    chk("tw_decode_ctl", 32'(ctl), 32'h0);
    chk("tw_err", 32'(err_code), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
